// File: rtl/exe_hazard_ctrl.sv
// Execute-stage pipeline controller: load-use and taken-branch hazards, multi-cycle
// mult/div hold of EXE, and a saturating stall-cycle performance counter.
module exe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [4:0]        ex_rd,
    input  logic [1:0]        ex_MemRead,
    input  logic              ex_RegWrite,
    input  logic              ex_md_start,
    input  logic              ex_branch_taken,
    input  logic              stall_cnt_clr,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              exe_flush,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {StRun, StMdWait} state_e;

    localparam bit               MdMulti = (MD_LAT > 1);
    // Entry cycle is already the first EXE cycle, so the wait counts from MD_LAT-2.
    localparam logic [CNT_W-1:0] MdInit  = CNT_W'(MdMulti ? MD_LAT - 2 : 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic               load_use;
    logic               hazards_live;
    logic               md_hold;

    assign load_use = (ex_MemRead != 2'b00) && ex_RegWrite && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hazards_live = 1'b0;
        md_hold      = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        exe_flush    = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;

        unique case (state_q)
            StRun: begin
                if (ex_md_start && MdMulti) begin
                    md_hold = 1'b1;
                    state_d = StMdWait;
                    cnt_d   = MdInit;
                end else begin
                    md_done      = ex_md_start;
                    hazards_live = 1'b1;
                end
            end
            StMdWait: begin
                if (cnt_q != '0) begin
                    md_hold = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    md_done      = 1'b1;
                    hazards_live = 1'b1;
                    state_d      = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (md_hold) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            exe_flush   = 1'b1;
            md_busy     = 1'b1;
        end

        // A taken branch squashes the ID instruction, so its load-use stall is moot.
        if (hazards_live) begin
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end

        if (!reset) begin
            pc_stall    = 1'b0;
            if_id_stall = 1'b0;
            if_id_flush = 1'b0;
            id_ex_stall = 1'b0;
            id_ex_flush = 1'b0;
            exe_flush   = 1'b0;
            md_busy     = 1'b0;
            md_done     = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Self-checking bench for exe_hazard_ctrl: table-driven single-cycle vectors plus
// hand-written mult/div, reset-abort and counter-saturation sequences.
module tb_exe_hazard_ctrl;

    typedef struct {
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] ex_rd;
        logic [1:0] mem_read;
        logic       reg_write;
        logic       md_start;
        logic       br;
        logic       clr;
        // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, exe_flush, md_busy, md_done}
        logic [7:0] exp;
    } vec_t;

    localparam logic [7:0] ExpIdle = 8'b0000_0000;
    localparam logic [7:0] ExpLu   = 8'b1100_1000;
    localparam logic [7:0] ExpBr   = 8'b0010_1000;
    localparam logic [7:0] ExpMd   = 8'b1101_0110;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt;
    logic [1:0]  ex_MemRead;
    logic        ex_RegWrite, ex_md_start, ex_branch_taken, stall_cnt_clr;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        exe_flush, md_busy, md_done;
    logic [15:0] stall_cnt;

    int          n_checks;
    int          n_fail;
    int          exp_stall;
    logic [7:0]  sb_q[$];
    vec_t        tbl[12];

    exe_hazard_ctrl #(.MD_LAT(4), .CNT_W(4), .PERF_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_rd           (ex_rd),
        .ex_MemRead      (ex_MemRead),
        .ex_RegWrite     (ex_RegWrite),
        .ex_md_start     (ex_md_start),
        .ex_branch_taken (ex_branch_taken),
        .stall_cnt_clr   (stall_cnt_clr),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .exe_flush       (exe_flush),
        .md_busy         (md_busy),
        .md_done         (md_done),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic [4:0] rd, input logic [1:0] mr,
                                input logic rw, input logic md, input logic br,
                                input logic clr, input logic [7:0] exp);
        vec_t v;
        v.id_rs = rs; v.id_rt = rt; v.uses_rs = urs; v.uses_rt = urt; v.ex_rd = rd;
        v.mem_read = mr; v.reg_write = rw; v.md_start = md; v.br = br; v.clr = clr;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                exe_flush, md_busy, md_done};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
        ex_rd = v.ex_rd; ex_MemRead = v.mem_read; ex_RegWrite = v.reg_write;
        ex_md_start = v.md_start; ex_branch_taken = v.br; stall_cnt_clr = v.clr;
    endtask

    // Entered just after a rising edge; returns just after the next one.
    task automatic drive_cycle(input string name, input vec_t v);
        logic [7:0] e;
        set_inputs(v);
        sb_q.push_back(v.exp);
        @(negedge clk);
        e = sb_q.pop_front();
        check({name, " outs"}, {8'h00, outs()}, {8'h00, e});
        check({name, " stall_cnt"}, stall_cnt, 16'(exp_stall));
        if (v.clr) exp_stall = 0;
        else if (e[7] && exp_stall != 65535) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    vec_t idle, lu, ones, v;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_stall = 0;

        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ExpIdle);
        lu   = mk(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, ExpLu);
        ones = mk(5'h1f, 5'h1f, 1'b1, 1'b1, 5'h1f, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, ExpIdle);

        tbl[0]  = idle;
        tbl[1]  = lu;
        tbl[2]  = mk(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ExpIdle);
        tbl[3]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, ExpIdle);
        tbl[4]  = mk(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, ExpLu);
        tbl[5]  = mk(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, ExpIdle);
        tbl[6]  = mk(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, ExpIdle);
        tbl[7]  = mk(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, ExpBr);
        tbl[8]  = mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, ExpBr);
        tbl[9]  = mk(5'd5, 5'd8, 1'b0, 1'b1, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, ExpIdle);
        tbl[10] = mk(5'd12, 5'd3, 1'b1, 1'b1, 5'd12, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, ExpLu);
        tbl[11] = idle;

        // Reset held with every input high.
        set_inputs(ones);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outs", {8'h00, outs()}, 16'h0000);
        check("reset stall_cnt", stall_cnt, 16'h0000);
        set_inputs(idle);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            drive_cycle($sformatf("vec%0d", i), tbl[i]);
        end

        // Mult/div, MD_LAT=4, start held high; branch at T+1 ignored; load-use at T+3 live.
        v = idle; v.md_start = 1'b1; v.exp = ExpMd;
        drive_cycle("md T", v);
        v.br = 1'b1;
        drive_cycle("md T+1 br", v);
        v.br = 1'b0;
        drive_cycle("md T+2", v);
        v = lu; v.md_start = 1'b1; v.exp = ExpLu | 8'b0000_0001;
        drive_cycle("md T+3 done", v);
        drive_cycle("md T+4 run", idle);

        // Reset asserted while in MD_WAIT aborts the operation.
        v = idle; v.md_start = 1'b1; v.exp = ExpMd;
        drive_cycle("mdrst T", v);
        set_inputs(ones);
        reset = 1'b0;
        #1;
        check("mdrst outs", {8'h00, outs()}, 16'h0000);
        check("mdrst stall_cnt", stall_cnt, 16'h0000);
        exp_stall = 0;
        @(negedge clk);
        set_inputs(idle);
        reset = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle("mdrst after", idle);
        drive_cycle("mdrst after2", idle);

        // Saturation: stall until the counter reaches all-ones, then once more.
        set_inputs(lu);
        repeat (65535 - exp_stall) @(posedge clk);
        @(negedge clk);
        check("sat reach", stall_cnt, 16'hffff);
        check("sat pc_stall", {15'd0, pc_stall}, 16'h0001);
        exp_stall = 65535;
        @(posedge clk);
        #1;
        drive_cycle("sat hold", lu);
        v = lu; v.clr = 1'b1;
        drive_cycle("clr with stall", v);
        drive_cycle("after clr", idle);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_hazard_ctrl.md
Name: exe_hazard_ctrl

Overview:
Pipeline controller that sequences the execute stage. It detects load-use hazards and taken branches resolved in EXE, and holds EXE for multi-cycle multiply/divide operations. It drives the stall/flush strobes for PC, IF/ID, ID/EX and the EXE output register (exe_flush). It also keeps a saturating stall-cycle performance counter.

Parameters:
MD_LAT, 4, total cycles a mult/div instruction occupies EXE (legal 1..15)
CNT_W, 4, width of internal latency counter
PERF_W, 16, width of stall_cnt

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
ex_rd  input  5  destination register of instruction in EXE (after RegDst mux)
ex_MemRead  input  2  EXE instruction load type; nonzero = load
ex_RegWrite  input  1  EXE instruction writes register file
ex_md_start  input  1  EXE instruction is mult/div
ex_branch_taken  input  1  Branch & condition true in EXE
stall_cnt_clr  input  1  synchronous clear of stall_cnt
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID register
if_id_flush  output  1  zero IF/ID register
id_ex_stall  output  1  hold ID/EX register
id_ex_flush  output  1  insert bubble into ID/EX
exe_flush  output  1  zero EXE control outputs (bubble to MEM)
md_busy  output  1  mult/div in progress, result not ready
md_done  output  1  one-cycle pulse: mult/div result valid this cycle
stall_cnt  output  PERF_W  count of cycles with pc_stall=1

Behaviour:
- States: RUN, MD_WAIT. Internal cnt[CNT_W-1:0].
- While reset=0: state=RUN, cnt=0, stall_cnt=0, all outputs forced 0. Reset mid-MD_WAIT aborts the op. No md_done is issued.
- Outputs are combinational from state, cnt and inputs. State, cnt and stall_cnt update on posedge clk.
- load_use = (ex_MemRead!=0) & ex_RegWrite & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority in RUN: ex_md_start (MD_LAT>1) > ex_branch_taken > load_use > none.
- RUN, ex_md_start & MD_LAT>1:
  - pc_stall=if_id_stall=id_ex_stall=exe_flush=md_busy=1.
  - next MD_WAIT, cnt<=MD_LAT-2.
- RUN, ex_md_start & MD_LAT==1: md_done=1, no stall, stay RUN.
- RUN, ex_branch_taken: if_id_flush=1, id_ex_flush=1, PC not stalled. load_use is suppressed that cycle.
- RUN, load_use: pc_stall=if_id_stall=1, id_ex_flush=1 (exactly one bubble). Stay RUN.
- MD_WAIT, cnt!=0: same stall set as MD entry, cnt<=cnt-1. Branch and load_use inputs ignored.
- MD_WAIT, cnt==0: md_done=1, md_busy=0. Branch and load_use rules apply as in RUN. Next RUN.
- Latency: mult/div occupies EXE exactly MD_LAT cycles, with MD_LAT-1 stall cycles and md_done in the last cycle.
- ex_md_start held high during MD_WAIT (same instruction) must not retrigger.
- stall_cnt increments by 1 each cycle pc_stall=1 and saturates at all-ones.
- stall_cnt_clr=1 forces stall_cnt=0 next edge and has priority over increment.
- ex_rd==0 never produces load_use.

Test Plan:
- Reset: hold reset=0 with all inputs 1 -> all outputs 0, stall_cnt=0. Release -> RUN.
- Load-use: ex_MemRead=2'b01, ex_RegWrite=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> one cycle pc_stall=if_id_stall=id_ex_flush=1. Next cycle (EXE holds bubble, ex_MemRead=0) all low. stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 with load_use conditions true -> if_id_flush=id_ex_flush=1, pc_stall=0.
- Mult/div, MD_LAT=4: ex_md_start=1 at cycle T in RUN, held high -> stalls and md_busy=1 at T..T+2, md_done=1 at T+3 only, RUN at T+4. stall_cnt+=3. Branch asserted at T+1 ignored.
- Reset at T+1 of MD_WAIT -> outputs 0 immediately. After release, state RUN, no md_done.
- Counter: force 65535 stall cycles then one more -> stall_cnt=16'hFFFF. Assert stall_cnt_clr alongside pc_stall=1 -> 0.
